mac_seq: RTL
============

Name: mac_seq

Overview:
Sequencer that runs a complete dot-product job on the shared MAC datapath. It accepts a job command, streams operand pairs through a valid/ready handshake, and issues the MAC instruction sequence: clear, first multiply, accumulate, optional saturate. It drives the MAC stall input whenever operands starve, waits out the MAC pipeline latency, then presents the 32-bit result plus 8 guard bits through an output handshake. It sits between the job-issuing control logic and the mac instance.

Parameters:
LEN_W, 8, width of the job length field (elements per job)
MAC_LAT, 2, cycles from an instruction being issued to its effect appearing on mac_result/mac_protect

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  job request pulse; sampled only in IDLE
len  in  LEN_W  number of operand pairs in the job; captured on an accepted start
mode  in  1  0 = single 16x16 lane, 1 = dual 8x8 packed lanes; captured on start
sat_en  in  1  1 = issue saturate step before drain; captured on start
op_valid  in  1  operand pair valid
op_a  in  16  multiplier operand
op_b  in  16  multiplicand operand
op_ready  out  1  operand accept; transfer when op_valid&op_ready
mac_instr  out  3  instruction to MAC
mac_a  out  16  multiplier to MAC
mac_b  out  16  multiplicand to MAC
mac_stall  out  1  stall to MAC
mac_result  in  32  MAC result
mac_protect  in  8  MAC guard bits
res_valid  out  1  result available
res_ready  in  1  result consumed; handshake when res_valid&res_ready
res_data  out  32  captured mac_result
res_protect  out  8  captured mac_protect
res_ovf  out  1  overflow flag
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, reset_n low): state=IDLE and count=0. All outputs 0, including res_data, res_protect, res_ovf and mac_stall. mac_instr=3'b000.
- States: IDLE, CLEAR, FIRST, ACCUM, SAT, DRAIN, OUT. The state register updates on the rising clk edge. mac_instr is decoded from the state.
- IDLE: mac_instr=000. On start=1, capture len, mode and sat_en; next state is CLEAR. start is ignored in every other state.
- CLEAR: mac_instr=000 for 1 cycle. If len==0, go to DRAIN; otherwise go to FIRST and load count=len.
- FIRST: mac_instr=001 (mode 0) or 101 (mode 1); op_ready=1.
  - On a transfer, decrement count. If count was 1, go to SAT (sat_en=1) or DRAIN (sat_en=0); otherwise go to ACCUM.
- ACCUM: mac_instr=010 (mode 0) or 110 (mode 1); op_ready=1. Decrement count on each transfer. When the last transfer occurs (count was 1), go to SAT or DRAIN as in FIRST.
- Starvation: in FIRST or ACCUM with op_valid=0, mac_stall=1, the state and count hold, and mac_instr keeps its value.
- mac_a/mac_b: equal op_a/op_b on transfer cycles, 0 otherwise. mac_stall=0 in all other states.
- SAT: mac_instr=011 (mode 0) or 111 (mode 1) for 1 cycle, then DRAIN.
- DRAIN: mac_instr=000 is not issued. Instead mac_instr holds the last issued code and mac_stall=0. A drain counter runs for exactly MAC_LAT cycles. In the final drain cycle, capture mac_result into res_data and mac_protect into res_protect; next state is OUT.
- Correction to DRAIN: a held accumulate would re-accumulate. Therefore, in DRAIN mac_instr=010/110 with mac_a=mac_b=0 (adds zero), or 000 when len==0.
- OUT: res_valid=1, and res_data/res_protect/res_ovf are stable. When res_ready=1, go to IDLE next cycle. A start arriving in that same cycle is ignored.
- res_ovf is computed at capture:
  - mode 0: res_protect != {8{res_data[31]}}.
  - mode 1: (res_protect[3:0] != {4{res_data[15]}}) | (res_protect[7:4] != {4{res_data[31]}}).
- Timing, no starvation (start accepted at edge 0): CLEAR is cycle 1, FIRST cycle 2, ACCUM cycles 3..len+1, SAT cycle len+2 (only if sat_en), DRAIN for the following MAC_LAT cycles. res_valid rises at cycle len+3+MAC_LAT (sat_en=1), one cycle earlier when sat_en=0, and at cycle 2+MAC_LAT when len==0.
- Starvation delays res_valid by exactly the number of starved cycles.
- Reset mid-job aborts immediately to IDLE with no result; the MAC is also reset by the same reset_n.

Test Plan:
- mode0, sat_en=1, len=4, a={1,2,3,4}, b={5,6,7,8}, MAC_LAT=2 -> res_valid rises at cycle 9, res_data=70, res_protect=0, res_ovf=0; instr trace 000,001,010,010,010,011,010,010.
- mode0, sat_en=0, len=3, a=b=-32768 -> res_data=0xC0000000, res_protect=0x00, res_ovf=1. Same job with sat_en=1 -> res_data=0x7FFFFFFF, res_ovf=0.
- Test 1 with op_valid low for 3 cycles after the 2nd transfer -> mac_stall=1 for exactly those 3 cycles, op_ready held, res_data=70, res_valid at cycle 12.
- mode1, sat_en=0, len=2, a=0x0203, b=0x0405 (both pairs) -> res_data=0x0010001E, res_protect=0, res_ovf=0.
- len=0 -> res_valid at cycle 4, res_data=0. Holding res_ready=0 for 5 cycles keeps res_valid=1 and data stable. A start pulse in OUT is ignored and busy stays 1.
- reset_n low during ACCUM -> busy, op_ready, res_valid and mac_stall go to 0 asynchronously. A fresh job after reset release gives the correct result.

Source files
------------

// File: rtl/mac_seq.sv
// mac_seq: sequences one dot-product job on the shared MAC datapath.
// A job is accepted in IDLE. The sequencer clears the MAC, streams the
// operand pairs with a FIRST multiply followed by ACCUM steps, optionally
// saturates, then waits out the MAC pipeline latency. It captures the
// result and guard bits and presents them through an output handshake.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   start, len, mode, sat_en         job request and its parameters
//   op_valid/op_ready, op_a, op_b    operand-pair stream (valid/ready)
//   mac_instr, mac_a, mac_b          instruction and operands to the MAC
//   mac_stall                        holds the MAC while operands starve
//   mac_result, mac_protect          MAC accumulator value and guard bits
//   res_valid/res_ready              result handshake
//   res_data, res_protect, res_ovf   captured result, guard bits, overflow
//   busy                             high whenever a job is in progress
module mac_seq #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             mode,
  input  logic             sat_en,
  input  logic             op_valid,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             op_ready,
  output logic [2:0]       mac_instr,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_stall,
  input  logic [31:0]      mac_result,
  input  logic [7:0]       mac_protect,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [7:0]       res_protect,
  output logic             res_ovf,
  output logic             busy
);

  localparam int unsigned   DW         = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT - 1);

  // Low two bits of the MAC instruction; bit 2 carries the lane mode.
  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_SAT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FIRST, S_ACCUM, S_SAT, S_DRAIN, S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             mode_q, mode_d;
  logic             sat_q, sat_d;
  logic             lenz_q, lenz_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [7:0]       res_prot_q, res_prot_d;
  logic             res_ovf_q, res_ovf_d;
  logic             ovf_now;

  // Guard bits must be a pure sign extension of each lane's top bit.
  assign ovf_now = mode_q
    ? ((mac_protect[3:0] != {4{mac_result[15]}}) |
       (mac_protect[7:4] != {4{mac_result[31]}}))
    : (mac_protect != {8{mac_result[31]}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      drain_q    <= '0;
      mode_q     <= 1'b0;
      sat_q      <= 1'b0;
      lenz_q     <= 1'b0;
      res_data_q <= '0;
      res_prot_q <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      drain_q    <= drain_d;
      mode_q     <= mode_d;
      sat_q      <= sat_d;
      lenz_q     <= lenz_d;
      res_data_q <= res_data_d;
      res_prot_q <= res_prot_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    drain_d    = '0;
    mode_d     = mode_q;
    sat_d      = sat_q;
    lenz_d     = lenz_q;
    res_data_d = res_data_q;
    res_prot_d = res_prot_q;
    res_ovf_d  = res_ovf_q;
    op_ready   = 1'b0;
    mac_instr  = {1'b0, OP_CLR};
    mac_a      = '0;
    mac_b      = '0;
    mac_stall  = 1'b0;
    res_valid  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // len is loaded into the element counter here; CLEAR only
          // needs to know whether the job is empty.
          count_d = len;
          mode_d  = mode;
          sat_d   = sat_en;
          lenz_d  = (len == '0);
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = lenz_q ? S_DRAIN : S_FIRST;
      end
      S_FIRST, S_ACCUM: begin
        mac_instr = {mode_q, (state_q == S_FIRST) ? OP_MUL : OP_ACC};
        op_ready  = 1'b1;
        if (op_valid) begin
          mac_a   = op_a;
          mac_b   = op_b;
          count_d = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) begin
            state_d = sat_q ? S_SAT : S_DRAIN;
          end else begin
            state_d = S_ACCUM;
          end
        end else begin
          mac_stall = 1'b1;
        end
      end
      S_SAT: begin
        mac_instr = {mode_q, OP_SAT};
        state_d   = S_DRAIN;
      end
      S_DRAIN: begin
        // Accumulating zero keeps the MAC busy without disturbing the sum;
        // an empty job keeps the cleared accumulator instead.
        mac_instr = lenz_q ? {1'b0, OP_CLR} : {mode_q, OP_ACC};
        if (drain_q == DRAIN_LAST) begin
          res_data_d = mac_result;
          res_prot_d = mac_protect;
          res_ovf_d  = ovf_now;
          state_d    = S_OUT;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign res_data    = res_data_q;
  assign res_protect = res_prot_q;
  assign res_ovf     = res_ovf_q;
  assign busy        = (state_q != S_IDLE);

endmodule
